id_ex_reg: RTL
==============

# id_ex_reg

ID/EX pipeline register of the ARM core. It captures decoded control, operand values and register indices from the ID stage and presents them to the EX stage, including the `src1`/`src2` indices consumed by the forwarding unit. It handles three events:
- pipeline freeze from the memory stage;
- branch flush from EX;
- load-use bubble insertion requested by the hazard unit.

A flush that arrives while frozen is remembered and applied once the freeze lifts.

## Interface
Parameters:
- `WORD`, 32, datapath width (`pc`, `val_rn`, `val_rm`).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `freeze`  in  1  hold all outputs (memory stall).
- `flush`  in  1  branch taken; kill the instruction entering EX.
- `bubble`  in  1  hazard stall; insert NOP into EX.
- `id_valid`  in  1  ID holds a real instruction.
- `id_wb_en`, `id_mem_read_en`, `id_mem_write_en`, `id_b`, `id_s`, `id_imm`  in  1 each  decoded control.
- `id_exe_cmd`  in  4  ALU command.
- `id_pc`, `id_val_rn`, `id_val_rm`  in  WORD  PC+4 and register operands.
- `id_shift_operand`  in  12  shifter operand.
- `id_signed_imm_24`  in  24  branch offset.
- `id_dest`, `id_src1`, `id_src2`  in  4  register indices.
- `id_status`  in  4  NZCV flags at decode.
- `exe_*`  out  same widths  registered copies of every `id_*` field, including `exe_valid`.
- `flush_pending`  out  1  a flush is held waiting for the freeze to release.

## Operation
- Control fields: `valid`, `wb_en`, `mem_read_en`, `mem_write_en`, `b`, `s`.
- Data fields: all other fields.
- Effective flush: `eff_flush = flush | flush_pending`.

Per rising edge, in priority order:
1. `freeze`=1: every `exe_*` output holds. If `flush`=1, set `flush_pending`=1; otherwise `flush_pending` holds.
2. `eff_flush`=1: control fields ← 0 and `flush_pending` ← 0. Data fields load from `id_*`.
3. `bubble`=1: control fields ← 0. Data fields load from `id_*`. `flush_pending` stays 0.
4. Otherwise: every field loads from `id_*`.

Additional rules:
- `exe_valid` loads `id_valid` only in case 4.
- Control outputs are never nonzero while `exe_valid`=0. On a case-4 load with `id_valid`=0, control fields are forced to 0.
- Data fields are loaded on every non-frozen edge. Their values for killed instructions are don't-care but deterministic.
- No arithmetic is performed; all fields are pure storage.

## Timing
- Latency: 1 cycle from `id_*` to `exe_*`.
- Reset (`rst`=0, async):
  - all `exe_*` outputs go to 0 immediately, including `exe_status`=4'h0 and `exe_exe_cmd`=4'h0;
  - `flush_pending`=0;
  - reset is held for as long as `rst`=0.
- Reset mid-freeze discards any pending flush.
- `freeze` and `flush` in the same cycle: outputs hold, and the flush is applied on the first edge with `freeze`=0.
- `freeze`=1 for N cycles: outputs are stable for N edges, and `flush_pending` remains 1 throughout.
- `flush` and `bubble` together: the flush wins, and `flush_pending` clears.
- Back-to-back flushes (no freeze): each one kills the instruction on that edge only.
- `flush_pending` is visible one edge after the `freeze`&`flush` cycle. It clears on the edge that applies the flush.

## Configuration
- `ID_EX_PERF_EN` defined adds two outputs:
  - `perf_stall_cnt` (32 bits): increments on every edge with `freeze`=1.
  - `perf_bubble_cnt` (32 bits): increments on every case-3 edge, and on case-2 edges where the incoming `id_valid`=1.
- Both counters reset to 0 on `rst`=0 and wrap from 32'hFFFFFFFF to 0.
- Undefined: the counters and their ports do not exist, and all other behaviour is identical.

## Test plan
- Reset then normal load: `rst` 0→1, then drive `id_valid`=1, `id_wb_en`=1, `id_dest`=4'h3, `id_src1`=4'h5, `id_val_rn`=32'h1234 → next edge gives `exe_valid`=1, `exe_wb_en`=1, `exe_dest`=3, `exe_src1`=5, `exe_val_rn`=32'h1234.
- Freeze hold: load an instruction, then `freeze`=1 for 3 cycles with changing `id_*` → `exe_*` remain unchanged for 3 edges, then update on the 4th.
- Flush during freeze: `freeze`=1 and `flush`=1 for one cycle, then `freeze`=1 for 2 more cycles → `flush_pending`=1 and outputs held; when `freeze` drops, the next edge gives `exe_valid`=0, `exe_wb_en`=0, and `flush_pending`=0.
- Bubble: `bubble`=1 with `id_mem_read_en`=1, `id_wb_en`=1 → `exe_valid`=0, `exe_mem_read_en`=0, `exe_wb_en`=0; `exe_dest` equals `id_dest`.
- Async reset mid-operation: assert `rst`=0 between edges while `flush_pending`=1 → all outputs are 0 immediately, and after release the first freeze-free edge is a normal load.
- With `ID_EX_PERF_EN`: 5 freeze cycles and 2 bubbles → `perf_stall_cnt`=5, `perf_bubble_cnt`=2.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: freeze hold, branch flush (remembered across a freeze) and load-use bubble.
// Optional performance counters are enabled with `define ID_EX_PERF_EN.
module id_ex_reg #(
   parameter int WORD = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            freeze,
   input  logic            flush,
   input  logic            bubble,
   input  logic            id_valid,
   input  logic            id_wb_en,
   input  logic            id_mem_read_en,
   input  logic            id_mem_write_en,
   input  logic            id_b,
   input  logic            id_s,
   input  logic            id_imm,
   input  logic [3:0]      id_exe_cmd,
   input  logic [WORD-1:0] id_pc,
   input  logic [WORD-1:0] id_val_rn,
   input  logic [WORD-1:0] id_val_rm,
   input  logic [11:0]     id_shift_operand,
   input  logic [23:0]     id_signed_imm_24,
   input  logic [3:0]      id_dest,
   input  logic [3:0]      id_src1,
   input  logic [3:0]      id_src2,
   input  logic [3:0]      id_status,
   output logic            exe_valid,
   output logic            exe_wb_en,
   output logic            exe_mem_read_en,
   output logic            exe_mem_write_en,
   output logic            exe_b,
   output logic            exe_s,
   output logic            exe_imm,
   output logic [3:0]      exe_exe_cmd,
   output logic [WORD-1:0] exe_pc,
   output logic [WORD-1:0] exe_val_rn,
   output logic [WORD-1:0] exe_val_rm,
   output logic [11:0]     exe_shift_operand,
   output logic [23:0]     exe_signed_imm_24,
   output logic [3:0]      exe_dest,
   output logic [3:0]      exe_src1,
   output logic [3:0]      exe_src2,
   output logic [3:0]      exe_status,
`ifdef ID_EX_PERF_EN
   output logic [31:0]     perf_stall_cnt,
   output logic [31:0]     perf_bubble_cnt,
`endif
   output logic            flush_pending
);

   // Control fields are the ones zeroed when an instruction is killed.
   typedef struct packed {
      logic valid;
      logic wb_en;
      logic mem_read_en;
      logic mem_write_en;
      logic b;
      logic s;
   } ctrl_t;

   typedef struct packed {
      logic            imm;
      logic [3:0]      exe_cmd;
      logic [WORD-1:0] pc;
      logic [WORD-1:0] val_rn;
      logic [WORD-1:0] val_rm;
      logic [11:0]     shift_operand;
      logic [23:0]     signed_imm_24;
      logic [3:0]      dest;
      logic [3:0]      src1;
      logic [3:0]      src2;
      logic [3:0]      status;
   } data_t;

   ctrl_t ctrl_q, ctrl_d, id_ctrl;
   data_t data_q, data_d, id_data;
   logic  pend_q, pend_d;
   logic  eff_flush;

   assign id_ctrl = '{valid:        id_valid,
                      wb_en:        id_wb_en,
                      mem_read_en:  id_mem_read_en,
                      mem_write_en: id_mem_write_en,
                      b:            id_b,
                      s:            id_s};

   assign id_data = '{imm:           id_imm,
                      exe_cmd:       id_exe_cmd,
                      pc:            id_pc,
                      val_rn:        id_val_rn,
                      val_rm:        id_val_rm,
                      shift_operand: id_shift_operand,
                      signed_imm_24: id_signed_imm_24,
                      dest:          id_dest,
                      src1:          id_src1,
                      src2:          id_src2,
                      status:        id_status};

   assign eff_flush = flush | pend_q;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      ctrl_d = ctrl_q;
      data_d = data_q;
      pend_d = pend_q;
      if (freeze) begin
         if (flush) pend_d = 1'b1;
      end else begin
         data_d = id_data;
         pend_d = 1'b0;
         if (eff_flush || bubble) ctrl_d = '0;
         else if (id_valid)       ctrl_d = id_ctrl;
         else                     ctrl_d = '0;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl_q <= '0;
         data_q <= '0;
         pend_q <= 1'b0;
      end else begin
         ctrl_q <= ctrl_d;
         data_q <= data_d;
         pend_q <= pend_d;
      end
   end

`ifdef ID_EX_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] bubble_cnt_q, bubble_cnt_d;
   logic        bubble_evt;

   // A flush that kills a real instruction counts as a lost slot, same as a bubble.
   assign bubble_evt = !freeze && (eff_flush ? id_valid : bubble);

   always_comb begin
      stall_cnt_d  = freeze     ? stall_cnt_q + 32'd1  : stall_cnt_q;
      bubble_cnt_d = bubble_evt ? bubble_cnt_q + 32'd1 : bubble_cnt_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign perf_stall_cnt  = stall_cnt_q;
   assign perf_bubble_cnt = bubble_cnt_q;
`endif

   assign exe_valid         = ctrl_q.valid;
   assign exe_wb_en         = ctrl_q.wb_en;
   assign exe_mem_read_en   = ctrl_q.mem_read_en;
   assign exe_mem_write_en  = ctrl_q.mem_write_en;
   assign exe_b             = ctrl_q.b;
   assign exe_s             = ctrl_q.s;
   assign exe_imm           = data_q.imm;
   assign exe_exe_cmd       = data_q.exe_cmd;
   assign exe_pc            = data_q.pc;
   assign exe_val_rn        = data_q.val_rn;
   assign exe_val_rm        = data_q.val_rm;
   assign exe_shift_operand = data_q.shift_operand;
   assign exe_signed_imm_24 = data_q.signed_imm_24;
   assign exe_dest          = data_q.dest;
   assign exe_src1          = data_q.src1;
   assign exe_src2          = data_q.src2;
   assign exe_status        = data_q.status;
   assign flush_pending     = pend_q;

endmodule
